// File: rtl/pulse_frame_receiver.sv
// pulse_frame_receiver: samples a WIDTH-bit MSB-first serial frame after a start strobe and holds it under valid/ack.
// Optional even-parity bit and parity_err port when PULSE_RX_PARITY_EN is defined.
module pulse_frame_receiver #(
  parameter int WIDTH = 8,
  localparam int CNTW = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  input  logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic [CNTW-1:0]  ones_count,
  output logic             valid,
  output logic             busy,
`ifdef PULSE_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, HOLD} state_t;
`ifdef PULSE_RX_PARITY_EN
  localparam state_t AFTER = PARITY;
  logic pbit;
`else
  localparam state_t AFTER = HOLD;
`endif
  state_t st, nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNTW-1:0] bitcnt;
  logic last, accept;
  assign last = bitcnt == CNTW'(WIDTH - 1);
  assign accept = st == HOLD && valid && ack;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = start ? SHIFT : IDLE;
      SHIFT:   nxt = last ? AFTER : SHIFT;
      PARITY:  nxt = HOLD;
      HOLD:    nxt = accept ? (start ? SHIFT : IDLE) : HOLD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk) st <= reset ? IDLE : nxt;
  // HOLD is entered right after the last sample; the first HOLD cycle publishes the word
  always_ff @(posedge Clk) begin
    if (reset) begin
      shreg      <= '0;
      bitcnt     <= '0;
      data_out   <= '0;
      ones_count <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
`ifdef PULSE_RX_PARITY_EN
      pbit       <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      busy   <= nxt == SHIFT || nxt == PARITY;
      bitcnt <= (st == SHIFT && !last) ? bitcnt + 1'b1 : '0;
      if (st == SHIFT) shreg <= {shreg[WIDTH-2:0], serial_in};
`ifdef PULSE_RX_PARITY_EN
      if (st == PARITY) pbit <= serial_in;
`endif
      if (st == HOLD && !valid) begin
        data_out   <= shreg;
        ones_count <= CNTW'($countones(shreg));
        valid      <= 1'b1;
`ifdef PULSE_RX_PARITY_EN
        parity_err <= ^{shreg, pbit};
`endif
      end else if (accept) begin
        valid      <= 1'b0;
`ifdef PULSE_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      if (st == HOLD && start && !accept) overrun <= 1'b1;
      else if (accept && !start) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pulse_frame_receiver.sv
// tb_pulse_frame_receiver: vector table, corner-case sequences and a randomized run against a frame-level model.
module tb_pulse_frame_receiver;
  localparam int W = 8;
`ifdef PULSE_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic Clk = 0, reset = 0, start = 0, serial_in = 0, ack = 0;
  logic [W-1:0] data_out;
  logic [3:0] ones_count;
  logic valid, busy, overrun, perr;
  int tests = 0, fails = 0;
  always #5 Clk = ~Clk;
  pulse_frame_receiver #(.WIDTH(W)) dut (
    .Clk(Clk), .reset(reset), .start(start), .serial_in(serial_in), .ack(ack),
    .data_out(data_out), .ones_count(ones_count), .valid(valid), .busy(busy),
`ifdef PULSE_RX_PARITY_EN
    .parity_err(perr),
`endif
    .overrun(overrun)
  );
`ifndef PULSE_RX_PARITY_EN
  assign perr = 1'b0;
`endif
  typedef struct { logic [W-1:0] d; int ones; } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic send_frame(input logic [W-1:0] d, input logic p);
    start = 1;
    tick;
    start = 0;
    for (int i = W - 1; i >= 0; i--) begin
      serial_in = d[i];
      tick;
    end
    if (P == 1) begin
      serial_in = p;
      tick;
    end
    serial_in = 0;
  endtask
  // frame-level reference: count bits in, build the word arithmetically, publish one cycle later
  bit col, pend, mv, mo, mperr, pb;
  int cnt, mones;
  logic [W-1:0] word, md;
  task automatic model(input bit r, input bit s, input bit sin, input bit a);
    if (r) begin
      col = 0; pend = 0; mv = 0; mo = 0; md = 0; mones = 0; mperr = 0;
    end else if (col) begin
      if (cnt < W) word = (word << 1) | W'(sin);
      else pb = sin;
      cnt++;
      if (cnt == W + P) begin col = 0; pend = 1; end
    end else if (pend) begin
      md = word;
      mones = 0;
      for (int i = 0; i < W; i++) mones += int'((word >> i) & 1);
      mperr = (P == 1) ? ((^word) ^ pb) : 1'b0;
      mv = 1; pend = 0;
      if (s) mo = 1;
    end else if (mv) begin
      if (a) begin
        mv = 0; mperr = 0;
        if (s) begin col = 1; cnt = 0; end
        else mo = 0;
      end else if (s) mo = 1;
    end else if (s) begin
      col = 1; cnt = 0;
    end
  endtask
  initial begin
    bit seen;
    bit r, s, sin, a;
    tbl[0] = '{8'hA5, 4}; tbl[1] = '{8'hFF, 8}; tbl[2] = '{8'h00, 0};
    tbl[3] = '{8'h3C, 4}; tbl[4] = '{8'h80, 1}; tbl[5] = '{8'h01, 1};
    reset = 1; start = 1; serial_in = 1; ack = 1;
    tick; tick;
    chk("rst_data", data_out, 0); chk("rst_ones", ones_count, 0);
    chk("rst_valid", valid, 0); chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0); chk("rst_perr", perr, 0);
    reset = 0; start = 0; serial_in = 0; ack = 0;
    tick;
    foreach (tbl[k]) begin
      send_frame(tbl[k].d, ^tbl[k].d);
      chk("tbl_pre_valid", valid, 0);
      tick;
      chk("tbl_valid", valid, 1); chk("tbl_data", data_out, tbl[k].d);
      chk("tbl_ones", ones_count, tbl[k].ones); chk("tbl_busy", busy, 0);
      chk("tbl_perr", perr, 0);
      ack = 1; tick; ack = 0;
      chk("tbl_ack_valid", valid, 0);
    end
    send_frame(8'hFF, 0);
    tick;
    for (int i = 0; i < 20; i++) begin
      chk("hold_valid", valid, 1); chk("hold_data", data_out, 8'hFF);
      tick;
    end
    ack = 1; tick; ack = 0;
    chk("hold_ack_valid", valid, 0);
    send_frame(8'hA5, 0);
    tick;
    start = 1; tick; start = 0;
    chk("ovr_set", overrun, 1); chk("ovr_data", data_out, 8'hA5); chk("ovr_valid", valid, 1);
    ack = 1; tick; ack = 0;
    chk("ovr_clr", overrun, 0); chk("ovr_ack_valid", valid, 0);
    send_frame(8'hA5, 0);
    tick;
    ack = 1; start = 1; tick; ack = 0; start = 0;
    chk("b2b_valid0", valid, 0); chk("b2b_busy", busy, 1);
    for (int i = W - 1; i >= 0; i--) begin
      serial_in = i[0] ? 1'b0 : 1'b0;
      serial_in = (8'h3C >> i) & 1;
      tick;
    end
    if (P == 1) begin serial_in = 0; tick; end
    chk("b2b_pre", valid, 0);
    tick;
    chk("b2b_valid", valid, 1); chk("b2b_data", data_out, 8'h3C); chk("b2b_ovr", overrun, 0);
    ack = 1; tick; ack = 0;
    start = 1; tick; start = 0;
    serial_in = 1; tick; tick; tick;
    reset = 1; tick; reset = 0;
    chk("midrst_busy", busy, 0); chk("midrst_valid", valid, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      serial_in = 1'($urandom);
      tick;
      if (valid) seen = 1;
    end
    chk("midrst_never_valid", seen, 0);
`ifdef PULSE_RX_PARITY_EN
    send_frame(8'hA5, 1);
    chk("par_pre", valid, 0);
    tick;
    chk("par_valid", valid, 1); chk("par_err", perr, 1);
    ack = 1; tick; ack = 0;
    chk("par_clr", perr, 0);
`endif
    for (int c = 0; c < 3000; c++) begin
      r = (c == 0) || ($urandom_range(199) == 0);
      s = $urandom_range(7) == 0;
      sin = 1'($urandom);
      a = $urandom_range(3) == 0;
      reset = r; start = s; serial_in = sin; ack = a;
      tick;
      model(r, s, sin, a);
      chk("rand", {data_out, ones_count, valid, busy, overrun, perr},
          {md, 4'(mones), mv, col, mo, mperr});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
